// File: rtl/fpga_ram_pkg.sv
// Shared types and constants for the two-port FPGA block RAM arbiter.
// State encoding, RAM data width and byte-lane count.
package fpga_ram_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OWN0 = 2'd1,
    ST_OWN1 = 2'd2
  } arb_state_e;

  localparam int DW    = 32;
  localparam int NLANE = 4;

endpackage

// File: rtl/fpga_ram_arb_pick.sv
// Pure combinational 2-way picker: returns the winning requester index.
// With rr set, contention goes to the requester that did not win last.
module fpga_ram_arb_pick (
  input  logic req0,
  input  logic req1,
  input  logic last,
  input  logic rr,
  output logic win
);

  always_comb begin
    win = 1'b0;
    unique case (1'b1)
      req0 && req1: win = rr & ~last;
      req1 && !req0: win = 1'b1;
      default: win = 1'b0;
    endcase
  end

endmodule

// File: rtl/fpga_ram_arbiter.sv
// Two-requester arbiter for one single-port byte-writable block RAM.
// Define FPGA_RAM_ARB_RR_EN for round-robin contention; default is fixed.
module fpga_ram_arbiter
  import fpga_ram_pkg::*;
#(
  parameter int AW       = 16,
  parameter int MAX_HOLD = 16,
  parameter int CW       = 8
) (
  input  logic             HCLK,
  input  logic             HRESETn,
  input  logic             m0_req,
  input  logic             m0_lock,
  input  logic [NLANE-1:0] m0_we,
  input  logic [AW-3:0]    m0_addr,
  input  logic [DW-1:0]    m0_wdata,
  output logic             m0_gnt,
  output logic             m0_rvalid,
  output logic [DW-1:0]    m0_rdata,
  input  logic             m1_req,
  input  logic             m1_lock,
  input  logic [NLANE-1:0] m1_we,
  input  logic [AW-3:0]    m1_addr,
  input  logic [DW-1:0]    m1_wdata,
  output logic             m1_gnt,
  output logic             m1_rvalid,
  output logic [DW-1:0]    m1_rdata,
  output logic             ram_cs,
  output logic [NLANE-1:0] ram_wren,
  output logic [AW-3:0]    ram_addr,
  output logic [DW-1:0]    ram_wdata,
  input  logic [DW-1:0]    ram_rdata
);

  localparam logic [CW-1:0] HOLD_MAX = CW'(MAX_HOLD);

  arb_state_e    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          rv0_q, rv0_d;
  logic          rv1_q, rv1_d;
  logic          last_w;
  logic          rr_w;
  logic          win;
  logic          own0, own1;
  logic          at_max;
  logic          frc0, frc1;

`ifdef FPGA_RAM_ARB_RR_EN
  logic last_q, last_d;

  assign rr_w   = 1'b1;
  assign last_w = last_q;

  always_comb begin
    last_d = last_q;
    if (m0_gnt) last_d = 1'b0;
    if (m1_gnt) last_d = 1'b1;
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) last_q <= 1'b1;
    else          last_q <= last_d;
  end
`else
  assign rr_w   = 1'b0;
  assign last_w = 1'b1;
`endif

  fpga_ram_arb_pick u_pick (
    .req0 (m0_req),
    .req1 (m1_req),
    .last (last_w),
    .rr   (rr_w),
    .win  (win)
  );

  // Dropping lock makes the owner state behave as IDLE this same cycle.
  assign own0   = (state_q == ST_OWN0) && m0_lock;
  assign own1   = (state_q == ST_OWN1) && m1_lock;
  assign at_max = cnt_q >= HOLD_MAX;
  assign frc0   = own1 && at_max && m0_req;
  assign frc1   = own0 && at_max && m1_req;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      rv0_q   <= 1'b0;
      rv1_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rv0_q   <= rv0_d;
      rv1_q   <= rv1_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rv0_d   = m0_gnt && (m0_we == '0);
    rv1_d   = m1_gnt && (m1_we == '0);
    if (m0_gnt) begin
      if (own0) begin
        cnt_d = at_max ? cnt_q : cnt_q + 1'b1;
      end else if (m0_lock) begin
        state_d = ST_OWN0;
        cnt_d   = CW'(1);
      end else begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    end else if (m1_gnt) begin
      if (own1) begin
        cnt_d = at_max ? cnt_q : cnt_q + 1'b1;
      end else if (m1_lock) begin
        state_d = ST_OWN1;
        cnt_d   = CW'(1);
      end else begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    end else if (!(own0 || own1)) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
    end
  end

  always_comb begin
    m0_gnt    = 1'b0;
    m1_gnt    = 1'b0;
    ram_wren  = '0;
    ram_addr  = '0;
    ram_wdata = '0;
    unique case (1'b1)
      frc0: m0_gnt = 1'b1;
      frc1: m1_gnt = 1'b1;
      own0 && !frc1: m0_gnt = m0_req;
      own1 && !frc0: m1_gnt = m1_req;
      default: begin
        m0_gnt = m0_req & ~win;
        m1_gnt = m1_req & win;
      end
    endcase
    if (m0_gnt) begin
      ram_wren  = m0_we;
      ram_addr  = m0_addr;
      ram_wdata = m0_wdata;
    end else if (m1_gnt) begin
      ram_wren  = m1_we;
      ram_addr  = m1_addr;
      ram_wdata = m1_wdata;
    end
    ram_cs = m0_gnt | m1_gnt;
  end

  assign m0_rvalid = rv0_q;
  assign m1_rvalid = rv1_q;
  assign m0_rdata  = ram_rdata;
  assign m1_rdata  = ram_rdata;

endmodule

// File: tb/tb_fpga_ram_arbiter.sv
// Bench for fpga_ram_arbiter: RAM model, grant checks, read scoreboard.
// Contention expectations follow FPGA_RAM_ARB_RR_EN when it is defined.
module tb_fpga_ram_arbiter;

  localparam int AW = 16;
  localparam int MH = 4;
  localparam int NW = 1 << (AW - 2);

  logic          HCLK = 1'b0;
  logic          HRESETn = 1'b0;
  logic          m0_req, m0_lock;
  logic [3:0]    m0_we;
  logic [AW-3:0] m0_addr;
  logic [31:0]   m0_wdata;
  logic          m0_gnt, m0_rvalid;
  logic [31:0]   m0_rdata;
  logic          m1_req, m1_lock;
  logic [3:0]    m1_we;
  logic [AW-3:0] m1_addr;
  logic [31:0]   m1_wdata;
  logic          m1_gnt, m1_rvalid;
  logic [31:0]   m1_rdata;
  logic          ram_cs;
  logic [3:0]    ram_wren;
  logic [AW-3:0] ram_addr;
  logic [31:0]   ram_wdata;
  logic [31:0]   ram_rdata;

  logic [31:0] ram [0:NW-1];
  logic [31:0] mdl [0:NW-1];
  logic [31:0] q0 [$];
  logic [31:0] q1 [$];
  logic [31:0] exp0, exp1;
  int total = 0;
  int bad = 0;

  fpga_ram_arbiter #(.AW(AW), .MAX_HOLD(MH), .CW(8)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn),
    .m0_req(m0_req), .m0_lock(m0_lock), .m0_we(m0_we),
    .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_gnt(m0_gnt),
    .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_lock(m1_lock), .m1_we(m1_we),
    .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_gnt(m1_gnt),
    .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
    .ram_cs(ram_cs), .ram_wren(ram_wren), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  always #5 HCLK = ~HCLK;

  function automatic logic [31:0] merge(logic [31:0] o,
                                        logic [31:0] n,
                                        logic [3:0] we);
    for (int b = 0; b < 4; b++)
      if (we[b]) o[8*b +: 8] = n[8*b +: 8];
    return o;
  endfunction

  always @(posedge HCLK) begin
    if (ram_cs) begin
      if (ram_wren == 4'h0) ram_rdata <= ram[ram_addr];
      else ram[ram_addr] <= merge(ram[ram_addr], ram_wdata, ram_wren);
    end
  end

  always @(negedge HCLK) begin
    if (HRESETn && m0_rvalid) begin
      total++;
      if (q0.size() == 0) begin
        bad++;
        $display("FAIL m0_rvalid_unexpected got=1 want=0");
      end else begin
        exp0 = q0.pop_front();
        if (m0_rdata !== exp0) begin
          bad++;
          $display("FAIL m0_rdata got=%h want=%h", m0_rdata, exp0);
        end
      end
    end
    if (HRESETn && m1_rvalid) begin
      total++;
      if (q1.size() == 0) begin
        bad++;
        $display("FAIL m1_rvalid_unexpected got=1 want=0");
      end else begin
        exp1 = q1.pop_front();
        if (m1_rdata !== exp1) begin
          bad++;
          $display("FAIL m1_rdata got=%h want=%h", m1_rdata, exp1);
        end
      end
    end
  end

  task automatic set0(logic r, logic l, logic [3:0] we,
                      logic [AW-3:0] a, logic [31:0] d);
    m0_req = r; m0_lock = l; m0_we = we;
    m0_addr = a; m0_wdata = d;
  endtask

  task automatic set1(logic r, logic l, logic [3:0] we,
                      logic [AW-3:0] a, logic [31:0] d);
    m1_req = r; m1_lock = l; m1_we = we;
    m1_addr = a; m1_wdata = d;
  endtask

  task automatic idle_all;
    set0(0, 0, 4'h0, '0, '0);
    set1(0, 0, 4'h0, '0, '0);
  endtask

  task automatic step;
    @(posedge HCLK);
    #1;
  endtask

  // Records an expected access: reads queue data, writes update the model.
  task automatic book(int p, logic [3:0] we,
                      logic [AW-3:0] a, logic [31:0] d);
    if (we == 4'h0) begin
      if (p == 0) q0.push_back(mdl[a]);
      else q1.push_back(mdl[a]);
    end else begin
      mdl[a] = merge(mdl[a], d, we);
    end
  endtask

  task automatic test_reset;
    idle_all();
    HRESETn = 1'b0;
    repeat (2) @(posedge HCLK);
    @(negedge HCLK);
    total++;
    if ({m0_rvalid, m1_rvalid, ram_cs, m0_gnt, m1_gnt} !== 5'b0) begin
      bad++;
      $display("FAIL reset_hold got=%b want=00000",
               {m0_rvalid, m1_rvalid, ram_cs, m0_gnt, m1_gnt});
    end
    step();
    HRESETn = 1'b1;
    @(negedge HCLK);
    total++;
    if ({ram_cs, ram_wren, ram_addr, ram_wdata} !== '0) begin
      bad++;
      $display("FAIL reset_idle_ram cs=%b wren=%h addr=%h want=0",
               ram_cs, ram_wren, ram_addr);
    end
  endtask

  task automatic test_reset_mid_read;
    step();
    set0(1, 0, 4'hF, 14'h010, 32'h1234_5678);
    @(negedge HCLK);
    total++;
    if ({m0_gnt, m1_gnt, ram_cs, ram_wren} !== 7'b101_1111) begin
      bad++;
      $display("FAIL rmr_write got=%b want=1011111",
               {m0_gnt, m1_gnt, ram_cs, ram_wren});
    end
    book(0, 4'hF, 14'h010, 32'h1234_5678);
    step();
    set0(1, 0, 4'h0, 14'h010, '0);
    @(negedge HCLK);
    total++;
    if ({m0_gnt, m1_gnt, ram_cs, ram_wren, ram_addr} !==
        {3'b101, 4'h0, 14'h010}) begin
      bad++;
      $display("FAIL rmr_read gnt=%b cs=%b wren=%h addr=%h want 1 0 1 0 010",
               {m0_gnt, m1_gnt}, ram_cs, ram_wren, ram_addr);
    end
    book(0, 4'h0, 14'h010, '0);
    step();
    idle_all();
    @(negedge HCLK);
    total++;
    if (m0_rvalid !== 1'b1) begin
      bad++;
      $display("FAIL rmr_rvalid got=%b want=1", m0_rvalid);
    end
    step();
    set0(1, 0, 4'h0, 14'h010, '0);
    @(negedge HCLK);
    total++;
    if (m0_gnt !== 1'b1) begin
      bad++;
      $display("FAIL rmr_regrant got=%b want=1", m0_gnt);
    end
    HRESETn = 1'b0;
    idle_all();
    step();
    @(negedge HCLK);
    total++;
    if (m0_rvalid !== 1'b0) begin
      bad++;
      $display("FAIL rmr_dropped got=%b want=0", m0_rvalid);
    end
    step();
    HRESETn = 1'b1;
    @(negedge HCLK);
    total++;
    if ({m0_rvalid, m1_rvalid} !== 2'b00) begin
      bad++;
      $display("FAIL rmr_after_rst got=%b want=00", {m0_rvalid, m1_rvalid});
    end
  endtask

  task automatic test_byte_lane;
    logic [3:0]  we [3];
    logic [31:0] d [3];
    we[0] = 4'hF; d[0] = 32'h1122_3344;
    we[1] = 4'h5; d[1] = 32'hAABB_CCDD;
    we[2] = 4'h0; d[2] = '0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (i < 3) set1(1, 0, we[i], 14'h020, d[i]);
      else idle_all();
      @(negedge HCLK);
      total++;
      if ({m0_gnt, m1_gnt, m0_rvalid} !== {1'b0, i < 3, 1'b0}) begin
        bad++;
        $display("FAIL byte_lane_c%0d got=%b want=0%b0", i,
                 {m0_gnt, m1_gnt, m0_rvalid}, i < 3);
      end
      if (i < 3) book(1, we[i], 14'h020, d[i]);
    end
    total++;
    if (mdl[14'h020] !== 32'h11BB_33DD) begin
      bad++;
      $display("FAIL byte_lane_model got=%h want=11bb33dd", mdl[14'h020]);
    end
    total++;
    if (q0.size() + q1.size() != 0) begin
      bad++;
      $display("FAIL byte_lane_drain got=%0d want=0", q0.size() + q1.size());
    end
  endtask

  task automatic test_contention;
    logic e1;
    for (int i = 0; i < 6; i++) begin
      step();
      set0(1, 0, 4'h0, 14'h010, '0);
      set1(1, 0, 4'h0, 14'h020, '0);
      @(negedge HCLK);
`ifdef FPGA_RAM_ARB_RR_EN
      e1 = (i % 2) == 1;
`else
      e1 = 1'b0;
`endif
      total++;
      if ({m0_gnt, m1_gnt} !== {~e1, e1}) begin
        bad++;
        $display("FAIL contend_c%0d got=%b want=%b", i,
                 {m0_gnt, m1_gnt}, {~e1, e1});
      end
      if (e1) book(1, 4'h0, 14'h020, '0);
      else book(0, 4'h0, 14'h010, '0);
    end
    step();
    set0(0, 0, 4'h0, '0, '0);
    @(negedge HCLK);
    total++;
    if ({m0_gnt, m1_gnt} !== 2'b01) begin
      bad++;
      $display("FAIL contend_m1_after got=%b want=01", {m0_gnt, m1_gnt});
    end
    book(1, 4'h0, 14'h020, '0);
    step();
    idle_all();
    repeat (2) step();
    total++;
    if (q0.size() + q1.size() != 0) begin
      bad++;
      $display("FAIL contend_drain got=%0d want=0", q0.size() + q1.size());
    end
  endtask

  task automatic test_lock_starve;
    for (int i = 0; i < 5; i++) begin
      step();
      set1(1, 1, 4'h0, 14'h020, '0);
      if (i > 0) set0(1, 0, 4'h0, 14'h010, '0);
      @(negedge HCLK);
      total++;
      if ({m0_gnt, m1_gnt} !== {i == 4, i < 4}) begin
        bad++;
        $display("FAIL starve_c%0d got=%b want=%b", i,
                 {m0_gnt, m1_gnt}, {i == 4, i < 4});
      end
      if (i < 4) book(1, 4'h0, 14'h020, '0);
      else book(0, 4'h0, 14'h010, '0);
    end
    step();
    idle_all();
    repeat (2) step();
    total++;
    if (q0.size() + q1.size() != 0) begin
      bad++;
      $display("FAIL starve_drain got=%0d want=0", q0.size() + q1.size());
    end
  endtask

  task automatic test_lock_gap;
    step();
    set0(1, 1, 4'h0, 14'h010, '0);
    @(negedge HCLK);
    total++;
    if ({m0_gnt, m1_gnt, ram_cs} !== 3'b101) begin
      bad++;
      $display("FAIL gap_own got=%b want=101", {m0_gnt, m1_gnt, ram_cs});
    end
    book(0, 4'h0, 14'h010, '0);
    for (int i = 0; i < 3; i++) begin
      step();
      set0(0, 1, 4'h0, 14'h010, '0);
      set1(1, 0, 4'h0, 14'h020, '0);
      @(negedge HCLK);
      total++;
      if ({m0_gnt, m1_gnt, ram_cs} !== 3'b000) begin
        bad++;
        $display("FAIL gap_c%0d got=%b want=000", i,
                 {m0_gnt, m1_gnt, ram_cs});
      end
    end
    step();
    set0(0, 0, 4'h0, '0, '0);
    @(negedge HCLK);
    total++;
    if ({m0_gnt, m1_gnt, ram_cs} !== 3'b011) begin
      bad++;
      $display("FAIL gap_release got=%b want=011", {m0_gnt, m1_gnt, ram_cs});
    end
    book(1, 4'h0, 14'h020, '0);
    step();
    idle_all();
    repeat (2) step();
    total++;
    if (q0.size() + q1.size() != 0) begin
      bad++;
      $display("FAIL gap_drain got=%0d want=0", q0.size() + q1.size());
    end
  endtask

  task automatic test_back_to_back;
    int ngnt;
    logic [3:0]    we;
    logic [AW-3:0] a;
    logic [31:0]   d;
    ngnt = 0;
    for (int i = 0; i < 200; i++) begin
      step();
      we = (i < 100) ? 4'hF : 4'h0;
      a  = AW'(14'h100 + (i % 100));
      d  = $urandom;
      set0(1, 0, we, a, d);
      @(negedge HCLK);
      if (m0_gnt === 1'b1) ngnt++;
      total++;
      if (m0_gnt !== 1'b1) begin
        bad++;
        $display("FAIL b2b_c%0d got=%b want=1", i, m0_gnt);
      end
      book(0, we, a, d);
    end
    step();
    idle_all();
    repeat (2) step();
    total++;
    if (ngnt != 200) begin
      bad++;
      $display("FAIL b2b_grants got=%0d want=200", ngnt);
    end
    total++;
    if (q0.size() + q1.size() != 0) begin
      bad++;
      $display("FAIL b2b_drain got=%0d want=0", q0.size() + q1.size());
    end
  endtask

  initial begin
    idle_all();
    test_reset();
    test_reset_mid_read();
    test_byte_lane();
    test_contention();
    test_lock_starve();
    test_lock_gap();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
